// File: rtl/data_memory_pipelined_if.sv
// data_memory_pipelined_if: load/store bus between the core and the data memory
// Signals:
//   data       write data (master -> slave)
//   write_addr write address (master -> slave)
//   we         write request (master -> slave)
//   read_addr  read address (master -> slave)
//   re         read request (master -> slave)
//   ready      requests are accepted this cycle (slave -> master)
//   q          read data (slave -> master)
//   q_valid    q carries the result of a read (slave -> master)
interface data_memory_pipelined_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  we;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  re;
  logic                  ready;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;
  modport master (output data, write_addr, we, read_addr, re, input ready, q, q_valid);
  modport slave (input data, write_addr, we, read_addr, re, output ready, q, q_valid);
endinterface

// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined: single-clock data memory with clear sweep and pipelined reads
// Ports:
//   clock_i  clock, all logic on posedge
//   reset_i  synchronous active-high reset
//   bus      slave side of data_memory_pipelined_if
// Optional feature: define RAW_BYPASS_EN for write-first same-address collisions
// (default is read-first).
module data_memory_pipelined #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    READ_LAT   = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic                    clock_i,
  input logic                    reset_i,
  data_memory_pipelined_if.slave bus
);
  typedef enum logic {CLEAR, RUN} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] pipe_q [READ_LAT];
  logic [READ_LAT-1:0]   vld_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_acc, rd_acc;
  always_ff @(posedge clock_i)
    if (reset_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = (state_q == CLEAR && &cnt_q) ? RUN : state_q;
    cnt_d   = (state_q == CLEAR) ? cnt_q + ADDR_WIDTH'(1) : cnt_q;
  end
  // Requests seen while reset is asserted are dropped even though ready is still 1.
  always_comb begin
    bus.ready = state_q == RUN;
    wr_acc    = bus.ready && bus.we && !reset_i;
    rd_acc    = bus.ready && bus.re && !reset_i;
  end
  always_ff @(posedge clock_i)
    if (!reset_i && state_q == CLEAR) mem[cnt_q] <= INIT_VALUE;
    else if (wr_acc) mem[bus.write_addr] <= bus.data;
`ifdef RAW_BYPASS_EN
  assign rd_word = (wr_acc && bus.write_addr == bus.read_addr) ? bus.data : mem[bus.read_addr];
`else
  assign rd_word = mem[bus.read_addr];
`endif
  // Data stages only load behind a valid bit, so the last stage (q) holds between reads.
  always_ff @(posedge clock_i)
    if (reset_i) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) pipe_q[0] <= rd_word;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) pipe_q[i] <= pipe_q[i-1];
      end
    end
  assign bus.q       = pipe_q[READ_LAT-1];
  assign bus.q_valid = vld_q[READ_LAT-1];
endmodule
